uart_rx_fifo_param: RTL

Parametrised UART receiver for the poyo-v peripheral bus. It has a configurable bit period, data width, parity mode and stop-bit count. A show-ahead receive FIFO decouples byte arrival from CPU reads. Sticky framing, parity and overrun status bits are cleared by software. It sits between the board RX pin and the memory-mapped UART register block.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM encoding and
// the default bit period used by the RX block and the future TX block.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int UART_CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO shared by the UART RX and TX paths. The head word is
// presented combinationally; when the FIFO runs empty the last head shown
// is held so the read port never shows stale storage.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_head;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = pop & ~empty;
    // A push into a full FIFO is still accepted when a pop frees the slot.
    assign w_do_push = push & (~full | w_do_pop);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign rdata     = empty ? r_hold : w_head;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Remember the last visible head so rdata holds while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_hold <= '0;
        else if (!empty) r_hold <= w_head;
    end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver feeding a show-ahead RX FIFO, with sticky
// framing / parity / overrun status cleared by software.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | line idle, waiting for a falling edge on rx_s
//   ST_START  | confirming the start bit at mid-bit (high = glitch)
//   ST_DATA   | sampling DATA_BITS payload bits, LSB first
//   ST_PARITY | sampling and checking the parity bit
//   ST_STOP   | sampling STOP_BITS stop bits, frame evaluated on last
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clear_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_fault;
    logic                 r_frm_fault;
    logic                 w_start_det;
    logic                 w_sample;
    logic                 w_shift_en;
    logic                 w_par_chk;
    logic                 w_stop_chk;
    logic                 w_frame_done;
    logic                 w_par_exp;
    logic                 w_frm_bad;
    logic                 w_good;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_start_det = (r_state == ST_IDLE) & r_rx_prev & ~r_rx_s;
    assign w_sample    = (r_state != ST_IDLE) && (r_cnt == '0);

    // Bit-period down-counter: half period to reach mid start bit, then full periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (w_start_det)       r_cnt <= CNT_HALF;
        else if (r_state != ST_IDLE) r_cnt <= (r_cnt == '0) ? CNT_FULL : r_cnt - 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_det) w_state_nxt = ST_START;
            ST_START:  if (w_sample) w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_sample && r_bit_idx == IDX_LAST)
                           w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_sample) w_state_nxt = ST_STOP;
            ST_STOP:   if (w_sample && r_stop_idx == STOP_LAST) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output strobes for the datapath.
    always_comb begin
        w_shift_en   = 1'b0;
        w_par_chk    = 1'b0;
        w_stop_chk   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_DATA:   w_shift_en = w_sample;
            ST_PARITY: w_par_chk  = w_sample;
            ST_STOP: begin
                w_stop_chk   = w_sample;
                w_frame_done = w_sample && (r_stop_idx == STOP_LAST);
            end
            default: ;
        endcase
    end

    assign w_par_exp = (^r_shift) ^ (PARITY == PARITY_ODD);

    // Receive datapath: shift register, bit indices and per-frame fault flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_par_fault <= 1'b0;
            r_frm_fault <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_bit_idx   <= '0;
                r_stop_idx  <= 1'b0;
                r_par_fault <= 1'b0;
                r_frm_fault <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_par_chk) r_par_fault <= (r_rx_s != w_par_exp);
            if (w_stop_chk) begin
                r_stop_idx <= r_stop_idx + 1'b1;
                if (!r_rx_s) r_frm_fault <= 1'b1;
            end
        end
    end

    // The last stop sample is folded in directly since its flag is not yet registered.
    assign w_frm_bad = r_frm_fault | ~r_rx_s;
    assign w_good    = w_frame_done & ~w_frm_bad & ~r_par_fault;
    assign w_push    = w_good & (~w_full | rd_en);

    // Sticky status: a set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_frame_done && w_frm_bad)                      frame_err <= 1'b1;
            else if (clear_err)                                 frame_err <= 1'b0;
            if (w_frame_done && !w_frm_bad && r_par_fault)      parity_err <= 1'b1;
            else if (clear_err)                                 parity_err <= 1'b0;
            if (w_good && w_full && !rd_en)                     overrun <= 1'b1;
            else if (clear_err)                                 overrun <= 1'b0;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (r_shift),
        .pop   (rd_en),
        .rdata (rd_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign rd_valid = ~w_empty;

endmodule
